pcie_axis_rx_tlp_splitter: RTL and testbench

//  Sits on the PCIe core's 64-bit AXIS RX master stream. Splits each TLP into a header descriptor,

---
 rtl/pcie_axis_pkg.sv | 48 ++++
 rtl/pcie_axis_hdr_fifo.sv | 55 +++++
 rtl/pcie_axis_rx_tlp_splitter.sv | 239 +++++++++++++++++++++++
 tb/tb_pcie_axis_rx_tlp_splitter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_axis_pkg.sv
// Shared types and constants for the PCIe AXIS RX TLP splitter.
//   rx_state_t  : splitter FSM states
//   hdr_desc_t  : header descriptor carried by the header queue
//   lowest_bar  : index of the lowest set bit of a 7-bit BAR hit vector
package pcie_axis_pkg;

    typedef enum logic [2:0] {
        ST_H0    = 3'd0,  // beat 0: DW0/DW1, drop decision
        ST_H1    = 3'd1,  // beat 1: DW2/DW3 or DW2/data0, descriptor push
        ST_PLD   = 3'd2,  // payload beats, aligned or realigned
        ST_FLUSH = 3'd3,  // emit the trailing residue DW
        ST_DROP  = 3'd4   // swallow the rest of a rejected TLP
    } rx_state_t;

    // tuser fields
    localparam int TUSER_ERR_FWD = 1;
    localparam int TUSER_BAR_LO  = 2;
    localparam int TUSER_BAR_HI  = 8;

    // DW0 fields
    localparam int DW0_EP_BIT       = 14;
    localparam int DW0_TYPE_LO      = 24;
    localparam int DW0_TYPE_HI      = 28;
    localparam int DW0_FMT_4DW_BIT  = 29;  // fmt[0]
    localparam int DW0_FMT_DATA_BIT = 30;  // fmt[1]

    localparam logic [4:0] TYPE_MEM = 5'b00000;

    localparam logic [7:0] KEEP_LO  = 8'h0F;
    localparam logic [7:0] KEEP_ALL = 8'hFF;

    typedef struct packed {
        logic [127:0] dw;        // {DW3,DW2,DW1,DW0}
        logic         is_4dw;
        logic         has_data;
        logic [2:0]   bar;
    } hdr_desc_t;

    function automatic logic [2:0] lowest_bar(input logic [6:0] hits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (hits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcie_axis_hdr_fifo.sv
// Synchronous FIFO of header descriptors.
//   i_clk/i_rst_n : clock, async active-low reset
//   i_push/i_din  : write a descriptor (accepted when not full, or when a pop frees the slot)
//   i_pop/o_dout  : head descriptor, removed when i_pop and not empty
//   o_full/o_empty: occupancy flags
module pcie_axis_hdr_fifo
    import pcie_axis_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  hdr_desc_t i_din,
    input  logic      i_pop,
    output hdr_desc_t o_dout,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pcie_axis_hdr_fifo: DEPTH must be a power of two >= 2");
    end

    hdr_desc_t    r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_pop;
    logic         w_do_push;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full queue only lands when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/pcie_axis_rx_tlp_splitter.sv
// Splits the 64-bit PCIe AXIS RX stream into header descriptors (queued) and a
// DW-realigned payload stream; filters TLPs by BAR, poison and error-forward.
//   user_clk, user_reset_n       : clock, async active-low reset
//   m_axis_rx_*                  : RX beats from the PCIe core (tready is ours)
//   hdr_valid/hdr_ready/hdr_*    : header descriptor queue head
//   pld_tdata/tkeep/tlast/tvalid : payload stream, first payload DW in [31:0]
//   stat_drop_cnt                : saturating count of discarded TLPs
module pcie_axis_rx_tlp_splitter
    import pcie_axis_pkg::*;
#(
    parameter int         C_DATA_WIDTH   = 64,
    parameter int         KEEP_WIDTH     = C_DATA_WIDTH / 8,
    parameter int         TCQ            = 1,
    parameter logic [6:0] BAR_MASK       = 7'b0000011,
    parameter bit         DROP_POISONED  = 1'b1,
    parameter int         HDR_FIFO_DEPTH = 4
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
    input  logic                    m_axis_rx_tlast,
    input  logic                    m_axis_rx_tvalid,
    input  logic [21:0]             m_axis_rx_tuser,
    output logic                    m_axis_rx_tready,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
    output logic [127:0]            hdr_dw,
    output logic                    hdr_4dw,
    output logic                    hdr_has_data,
    output logic [2:0]              hdr_bar,
    output logic [C_DATA_WIDTH-1:0] pld_tdata,
    output logic [KEEP_WIDTH-1:0]   pld_tkeep,
    output logic                    pld_tlast,
    output logic                    pld_tvalid,
    input  logic                    pld_tready,
    output logic [15:0]             stat_drop_cnt
);

    if (C_DATA_WIDTH != 64) begin : g_bad_width
        $error("pcie_axis_rx_tlp_splitter: only C_DATA_WIDTH=64 is supported");
    end
    // TCQ only shapes simulation-model timing; the RTL itself carries no delays.
    if (TCQ < 0) begin : g_bad_tcq
        $error("pcie_axis_rx_tlp_splitter: TCQ must be non-negative");
    end

    rx_state_t                r_state, w_nxt;
    logic                     r_run;        // low during and one cycle after reset: holds tready off
    logic [63:0]              r_hdr_lo;     // {DW1,DW0}
    logic [2:0]               r_bar;
    logic                     r_realign;
    logic [31:0]              r_residue;
    logic [C_DATA_WIDTH-1:0]  r_pld_tdata;
    logic [KEEP_WIDTH-1:0]    r_pld_tkeep;
    logic                     r_pld_tlast;
    logic                     r_pld_tvalid;
    logic [15:0]              r_drop_cnt;

    logic                     w_tready;
    logic                     w_out_free;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [6:0]               w_bar_hit;
    logic                     w_drop_tlp;
    logic                     w_push;
    logic                     w_lat_hdr;
    logic                     w_drop_inc;
    logic                     w_ld_pld;
    logic                     w_ld_res;
    logic                     w_nxt_realign;
    logic [C_DATA_WIDTH-1:0]  w_pld_d;
    logic [KEEP_WIDTH-1:0]    w_pld_k;
    logic                     w_pld_l;
    hdr_desc_t                w_desc;
    hdr_desc_t                w_head;
    logic                     w_unused;

    assign w_unused   = ^{m_axis_rx_tuser[21:9], m_axis_rx_tuser[0]};
    assign w_out_free = !r_pld_tvalid || pld_tready;
    assign w_bar_hit  = m_axis_rx_tuser[TUSER_BAR_HI:TUSER_BAR_LO] & BAR_MASK;

    assign w_drop_tlp = m_axis_rx_tuser[TUSER_ERR_FWD]
                      | (DROP_POISONED & m_axis_rx_tdata[DW0_EP_BIT])
                      | ((m_axis_rx_tdata[DW0_TYPE_HI:DW0_TYPE_LO] == TYPE_MEM) && (w_bar_hit == 7'd0));

    // Descriptor is assembled from the latched first beat plus the current (second) beat.
    always_comb begin
        w_desc          = '0;
        w_desc.dw       = {r_hdr_lo[DW0_FMT_4DW_BIT] ? m_axis_rx_tdata[63:32] : 32'h0,
                           m_axis_rx_tdata[31:0], r_hdr_lo};
        w_desc.is_4dw   = r_hdr_lo[DW0_FMT_4DW_BIT];
        w_desc.has_data = r_hdr_lo[DW0_FMT_DATA_BIT];
        w_desc.bar      = r_bar;
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) r_state <= ST_H0;
        else               r_state <= w_nxt;
    end

    always_comb begin
        w_nxt         = r_state;
        w_tready      = 1'b0;
        w_push        = 1'b0;
        w_lat_hdr     = 1'b0;
        w_drop_inc    = 1'b0;
        w_ld_pld      = 1'b0;
        w_ld_res      = 1'b0;
        w_nxt_realign = r_realign;
        w_pld_d       = m_axis_rx_tdata;
        w_pld_k       = m_axis_rx_tkeep;
        w_pld_l       = m_axis_rx_tlast;
        if (r_run) begin
            case (r_state)
                ST_H0: begin
                    // Stall on full regardless of hdr_ready: the push happens a beat later.
                    w_tready = !w_fifo_full;
                    if (m_axis_rx_tvalid && w_tready) begin
                        if (w_drop_tlp) begin
                            w_drop_inc = 1'b1;
                            w_nxt      = m_axis_rx_tlast ? ST_H0 : ST_DROP;
                        end else if (!m_axis_rx_tlast) begin
                            w_lat_hdr = 1'b1;
                            w_nxt     = ST_H1;
                        end
                    end
                end
                ST_H1: begin
                    w_tready = w_out_free;
                    if (m_axis_rx_tvalid && w_tready) begin
                        w_push = 1'b1;
                        if (r_hdr_lo[DW0_FMT_4DW_BIT]) begin
                            w_nxt_realign = 1'b0;
                            w_nxt         = m_axis_rx_tlast ? ST_H0 : ST_PLD;
                        end else if (!r_hdr_lo[DW0_FMT_DATA_BIT]) begin
                            w_nxt = ST_H0;
                        end else begin
                            // data0 sits in the upper DW; hold it until the next beat.
                            w_ld_res      = 1'b1;
                            w_nxt_realign = 1'b1;
                            w_nxt         = m_axis_rx_tlast ? ST_FLUSH : ST_PLD;
                        end
                    end
                end
                ST_PLD: begin
                    w_tready = w_out_free;
                    if (m_axis_rx_tvalid && w_tready) begin
                        w_ld_pld = 1'b1;
                        if (r_realign) begin
                            w_ld_res = 1'b1;
                            w_pld_d  = {m_axis_rx_tdata[31:0], r_residue};
                            w_pld_k  = KEEP_ALL;
                            if (m_axis_rx_tlast) begin
                                // Full last beat leaves one DW behind for FLUSH.
                                w_pld_l = (m_axis_rx_tkeep == KEEP_LO);
                                w_nxt   = (m_axis_rx_tkeep == KEEP_LO) ? ST_H0 : ST_FLUSH;
                            end
                        end else if (m_axis_rx_tlast) begin
                            w_nxt = ST_H0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_out_free) begin
                        w_ld_pld = 1'b1;
                        w_pld_d  = {32'h0, r_residue};
                        w_pld_k  = KEEP_LO;
                        w_pld_l  = 1'b1;
                        w_nxt    = ST_H0;
                    end
                end
                ST_DROP: begin
                    w_tready = 1'b1;
                    if (m_axis_rx_tvalid && m_axis_rx_tlast) w_nxt = ST_H0;
                end
                default: w_nxt = ST_H0;
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_run        <= 1'b0;
            r_hdr_lo     <= '0;
            r_bar        <= '0;
            r_realign    <= 1'b0;
            r_residue    <= '0;
            r_pld_tdata  <= '0;
            r_pld_tkeep  <= '0;
            r_pld_tlast  <= 1'b0;
            r_pld_tvalid <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_run     <= 1'b1;
            r_realign <= w_nxt_realign;
            if (w_lat_hdr) begin
                r_hdr_lo <= m_axis_rx_tdata;
                r_bar    <= lowest_bar(w_bar_hit);
            end
            if (w_ld_res) r_residue <= m_axis_rx_tdata[63:32];
            if (w_ld_pld) begin
                r_pld_tdata  <= w_pld_d;
                r_pld_tkeep  <= w_pld_k;
                r_pld_tlast  <= w_pld_l;
                r_pld_tvalid <= 1'b1;
            end else if (pld_tready) begin
                r_pld_tvalid <= 1'b0;
            end
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    pcie_axis_hdr_fifo #(
        .DEPTH   (HDR_FIFO_DEPTH)
    ) u_hdr_fifo (
        .i_clk   (user_clk),
        .i_rst_n (user_reset_n),
        .i_push  (w_push),
        .i_din   (w_desc),
        .i_pop   (hdr_ready),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign m_axis_rx_tready = w_tready;
    assign hdr_valid        = !w_fifo_empty;
    assign hdr_dw           = w_head.dw;
    assign hdr_4dw          = w_head.is_4dw;
    assign hdr_has_data     = w_head.has_data;
    assign hdr_bar          = w_head.bar;
    assign pld_tdata        = r_pld_tdata;
    assign pld_tkeep        = r_pld_tkeep;
    assign pld_tlast        = r_pld_tlast;
    assign pld_tvalid       = r_pld_tvalid;
    assign stat_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_pcie_axis_rx_tlp_splitter.sv
module tb_pcie_axis_rx_tlp_splitter;

    logic          user_clk = 1'b0;
    logic          user_reset_n;
    logic [63:0]   rx_tdata;
    logic [7:0]    rx_tkeep;
    logic          rx_tlast;
    logic          rx_tvalid;
    logic [21:0]   rx_tuser;
    logic          rx_tready;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [127:0]  hdr_dw;
    logic          hdr_4dw;
    logic          hdr_has_data;
    logic [2:0]    hdr_bar;
    logic [63:0]   pld_tdata;
    logic [7:0]    pld_tkeep;
    logic          pld_tlast;
    logic          pld_tvalid;
    logic          pld_tready;
    logic [15:0]   stat_drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;

    always #5 user_clk = ~user_clk;

    pcie_axis_rx_tlp_splitter dut (
        .user_clk         (user_clk),
        .user_reset_n     (user_reset_n),
        .m_axis_rx_tdata  (rx_tdata),
        .m_axis_rx_tkeep  (rx_tkeep),
        .m_axis_rx_tlast  (rx_tlast),
        .m_axis_rx_tvalid (rx_tvalid),
        .m_axis_rx_tuser  (rx_tuser),
        .m_axis_rx_tready (rx_tready),
        .hdr_valid        (hdr_valid),
        .hdr_ready        (hdr_ready),
        .hdr_dw           (hdr_dw),
        .hdr_4dw          (hdr_4dw),
        .hdr_has_data     (hdr_has_data),
        .hdr_bar          (hdr_bar),
        .pld_tdata        (pld_tdata),
        .pld_tkeep        (pld_tkeep),
        .pld_tlast        (pld_tlast),
        .pld_tvalid       (pld_tvalid),
        .pld_tready       (pld_tready),
        .stat_drop_cnt    (stat_drop_cnt)
    );

    typedef struct packed {
        logic [127:0] dw;
        logic         is4;
        logic         hd;
        logic [2:0]   bar;
    } hrec_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } prec_t;

    hrec_t hq[$];
    prec_t pq[$];

    // Handshakes are captured mid-cycle; the transfer completes on the next rising edge.
    always @(negedge user_clk) begin
        if (user_reset_n && hdr_valid && hdr_ready) hq.push_back({hdr_dw, hdr_4dw, hdr_has_data, hdr_bar});
        if (user_reset_n && pld_tvalid && pld_tready) pq.push_back({pld_tdata, pld_tkeep, pld_tlast});
    end

    typedef struct {
        string            name;
        int               nb;
        logic [3:0][63:0] d;
        logic [3:0][7:0]  k;
        logic [21:0]      u;
        bit               eh;
        logic [127:0]     edw;
        logic             e4;
        logic             ehd;
        logic [2:0]       ebar;
        int               np;
        logic [2:0][63:0] pd;
        logic [2:0][7:0]  pk;
        logic [2:0]       pl;
        bit               edrop;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; bounded wait.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [21:0] u);
        int n;
        n = 0;
        rx_tdata  = d;
        rx_tkeep  = k;
        rx_tlast  = l;
        rx_tuser  = u;
        rx_tvalid = 1'b1;
        forever begin
            @(negedge user_clk);
            if (rx_tready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: tready stuck at %b for beat %h", rx_tready, d);
                break;
            end
        end
        @(posedge user_clk);
        #1;
        rx_tvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] bpd [3];
        logic [7:0]  bpk [3];
        logic        bpl [3];

        tv[0] = '{"mwr3_len1", 2,
                  {64'h0, 64'h0, 64'hA5A5A5A5_00001000, 64'h0000000F_40000001},
                  {8'h00, 8'h00, 8'hFF, 8'hFF}, 22'h4,
                  1'b1, 128'h00000000_00001000_0000000F_40000001, 1'b0, 1'b1, 3'd0,
                  1, {64'h0, 64'h0, 64'h00000000_A5A5A5A5}, {8'h00, 8'h00, 8'h0F}, 3'b001, 1'b0};
        tv[1] = '{"mwr3_len4", 4,
                  {64'h00000000_44444444, 64'h33333333_22222222, 64'h11111111_00002000, 64'h0000000F_40000004},
                  {8'h0F, 8'hFF, 8'hFF, 8'hFF}, 22'h8,
                  1'b1, 128'h00000000_00002000_0000000F_40000004, 1'b0, 1'b1, 3'd1,
                  2, {64'h0, 64'h44444444_33333333, 64'h22222222_11111111}, {8'h00, 8'hFF, 8'hFF}, 3'b010, 1'b0};
        tv[2] = '{"mwr4_len2", 3,
                  {64'h0, 64'hBBBBBBBB_AAAAAAAA, 64'h00000040_00000001, 64'h000000FF_60000002},
                  {8'h00, 8'hFF, 8'hFF, 8'hFF}, 22'hC,
                  1'b1, 128'h00000040_00000001_000000FF_60000002, 1'b1, 1'b1, 3'd0,
                  1, {64'h0, 64'h0, 64'hBBBBBBBB_AAAAAAAA}, {8'h00, 8'h00, 8'hFF}, 3'b001, 1'b0};
        tv[3] = '{"mrd_bar_miss", 2,
                  {64'h0, 64'h0, 64'h00000000_00003000, 64'h0000000F_00000001},
                  {8'h00, 8'h00, 8'h0F, 8'hFF}, 22'h10,
                  1'b0, 128'h0, 1'b0, 1'b0, 3'd0,
                  0, {64'h0, 64'h0, 64'h0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1'b1};
        tv[4] = '{"mwr_poisoned", 2,
                  {64'h0, 64'h0, 64'h12345678_00004000, 64'h0000000F_40004001},
                  {8'h00, 8'h00, 8'hFF, 8'hFF}, 22'h4,
                  1'b0, 128'h0, 1'b0, 1'b0, 3'd0,
                  0, {64'h0, 64'h0, 64'h0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1'b1};
        tv[5] = '{"mwr_err_fwd", 2,
                  {64'h0, 64'h0, 64'hA5A5A5A5_00001000, 64'h0000000F_40000001},
                  {8'h00, 8'h00, 8'hFF, 8'hFF}, 22'h6,
                  1'b0, 128'h0, 1'b0, 1'b0, 3'd0,
                  0, {64'h0, 64'h0, 64'h0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1'b1};
        tv[6] = '{"cpld_no_bar", 2,
                  {64'h0, 64'h0, 64'hDEADBEEF_00010000, 64'h00000000_4A000001},
                  {8'h00, 8'h00, 8'hFF, 8'hFF}, 22'h0,
                  1'b1, 128'h00000000_00010000_00000000_4A000001, 1'b0, 1'b1, 3'd0,
                  1, {64'h0, 64'h0, 64'h00000000_DEADBEEF}, {8'h00, 8'h00, 8'h0F}, 3'b001, 1'b0};
        tv[7] = '{"mwr3_len3_flush", 3,
                  {64'h0, 64'h77777777_66666666, 64'h55555555_00005000, 64'h0000000F_40000003},
                  {8'h00, 8'hFF, 8'hFF, 8'hFF}, 22'h1F8,
                  1'b1, 128'h00000000_00005000_0000000F_40000003, 1'b0, 1'b1, 3'd1,
                  2, {64'h0, 64'h00000000_77777777, 64'h66666666_55555555}, {8'h00, 8'h0F, 8'hFF}, 3'b010, 1'b0};

        user_reset_n = 1'b0;
        rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0; rx_tvalid = 1'b0; rx_tuser = '0;
        hdr_ready = 1'b1;
        pld_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge user_clk);
        chk("rst_tready", rx_tready, 1'b0);
        chk("rst_hdr_valid", hdr_valid, 1'b0);
        chk("rst_pld_tvalid", pld_tvalid, 1'b0);
        chk("rst_drop_cnt", stat_drop_cnt, 16'h0);
        @(posedge user_clk); #1;
        user_reset_n = 1'b1;
        idle(2);

        // Table-driven single-TLP vectors
        for (int t = 0; t < 8; t++) begin
            hq.delete();
            pq.delete();
            for (int b = 0; b < tv[t].nb; b++)
                send(tv[t].d[b], tv[t].k[b], (b == tv[t].nb - 1), tv[t].u);
            idle(6);
            if (tv[t].edrop) exp_drops++;
            chk({tv[t].name, " hdr_cnt"}, hq.size(), tv[t].eh ? 1 : 0);
            if (tv[t].eh && hq.size() > 0) begin
                chk({tv[t].name, " hdr_dw"}, hq[0].dw, tv[t].edw);
                chk({tv[t].name, " hdr_4dw"}, hq[0].is4, tv[t].e4);
                chk({tv[t].name, " hdr_has_data"}, hq[0].hd, tv[t].ehd);
                chk({tv[t].name, " hdr_bar"}, hq[0].bar, tv[t].ebar);
            end
            chk({tv[t].name, " pld_cnt"}, pq.size(), tv[t].np);
            for (int i = 0; i < tv[t].np && i < pq.size(); i++) begin
                chk({tv[t].name, " pld_data"}, pq[i].d, tv[t].pd[i]);
                chk({tv[t].name, " pld_keep"}, pq[i].k, tv[t].pk[i]);
                chk({tv[t].name, " pld_last"}, pq[i].l, tv[t].pl[i]);
            end
            chk({tv[t].name, " drop_cnt"}, stat_drop_cnt, exp_drops);
        end

        // Header queue fills with 4 MRd; the 5th stalls until one pop.
        hq.delete();
        pq.delete();
        hdr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(64'h0000000F_00000001, 8'hFF, 1'b0, 22'h4);
            send({32'h0, 32'h0000A000 + 32'(i * 256)}, 8'h0F, 1'b1, 22'h4);
        end
        rx_tdata = 64'h0000000F_00000001; rx_tkeep = 8'hFF; rx_tlast = 1'b0; rx_tuser = 22'h4;
        rx_tvalid = 1'b1;
        @(negedge user_clk);
        chk("full_h0_tready", rx_tready, 1'b0);
        repeat (3) @(negedge user_clk);
        chk("full_h0_tready_hold", rx_tready, 1'b0);
        chk("full_hdr_valid", hdr_valid, 1'b1);
        @(posedge user_clk); #1;
        hdr_ready = 1'b1;
        @(posedge user_clk); #1;
        hdr_ready = 1'b0;
        chk("full_one_pop", hq.size(), 1);
        send(64'h0000000F_00000001, 8'hFF, 1'b0, 22'h4);
        send(64'h00000000_0000A400, 8'h0F, 1'b1, 22'h4);
        hdr_ready = 1'b1;
        idle(8);
        chk("full_total_hdrs", hq.size(), 5);
        if (hq.size() == 5) begin
            chk("full_first_addr", hq[0].dw[95:64], 32'h0000A000);
            chk("full_fifth_addr", hq[4].dw[95:64], 32'h0000A400);
            chk("full_fifth_has_data", hq[4].hd, 1'b0);
        end
        chk("full_no_pld", pq.size(), 0);

        // 3DW len=5 with pld_tready toggling every cycle.
        hq.delete();
        pq.delete();
        pld_tready = 1'b0;
        fork
            begin
                send(64'h0000000F_40000005, 8'hFF, 1'b0, 22'h4);
                send(64'hC0C0C0C0_00006000, 8'hFF, 1'b0, 22'h4);
                send(64'hC2C2C2C2_C1C1C1C1, 8'hFF, 1'b0, 22'h4);
                send(64'hC4C4C4C4_C3C3C3C3, 8'hFF, 1'b1, 22'h4);
            end
            begin
                repeat (40) begin
                    @(posedge user_clk); #1;
                    pld_tready = ~pld_tready;
                end
            end
        join
        pld_tready = 1'b1;
        idle(6);
        bpd[0] = 64'hC1C1C1C1_C0C0C0C0; bpk[0] = 8'hFF; bpl[0] = 1'b0;
        bpd[1] = 64'hC3C3C3C3_C2C2C2C2; bpk[1] = 8'hFF; bpl[1] = 1'b0;
        bpd[2] = 64'h00000000_C4C4C4C4; bpk[2] = 8'h0F; bpl[2] = 1'b1;
        chk("bp_pld_cnt", pq.size(), 3);
        for (int i = 0; i < 3 && i < pq.size(); i++) begin
            chk("bp_pld_data", pq[i].d, bpd[i]);
            chk("bp_pld_keep", pq[i].k, bpk[i]);
            chk("bp_pld_last", pq[i].l, bpl[i]);
        end
        chk("bp_hdr_cnt", hq.size(), 1);

        // Reset in the middle of a payload with a descriptor and payload pending.
        hq.delete();
        pq.delete();
        hdr_ready = 1'b0;
        pld_tready = 1'b0;
        send(64'h0000000F_40000008, 8'hFF, 1'b0, 22'h4);
        send(64'hE0E0E0E0_00007000, 8'hFF, 1'b0, 22'h4);
        send(64'hE2E2E2E2_E1E1E1E1, 8'hFF, 1'b0, 22'h4);
        @(negedge user_clk);
        chk("pre_rst_pld_tvalid", pld_tvalid, 1'b1);
        chk("pre_rst_hdr_valid", hdr_valid, 1'b1);
        chk("pre_rst_drop_cnt", stat_drop_cnt, exp_drops);
        @(posedge user_clk); #1;
        user_reset_n = 1'b0;
        @(negedge user_clk);
        chk("midrst_tready", rx_tready, 1'b0);
        chk("midrst_hdr_valid", hdr_valid, 1'b0);
        chk("midrst_pld_tvalid", pld_tvalid, 1'b0);
        chk("midrst_drop_cnt", stat_drop_cnt, 16'h0);
        @(posedge user_clk); #1;
        user_reset_n = 1'b1;
        hdr_ready = 1'b1;
        pld_tready = 1'b1;
        exp_drops = 0;
        hq.delete();
        pq.delete();
        send(tv[0].d[0], tv[0].k[0], 1'b0, tv[0].u);
        send(tv[0].d[1], tv[0].k[1], 1'b1, tv[0].u);
        idle(6);
        chk("postrst_hdr_cnt", hq.size(), 1);
        if (hq.size() > 0) chk("postrst_hdr_dw", hq[0].dw, tv[0].edw);
        chk("postrst_pld_cnt", pq.size(), 1);
        if (pq.size() > 0) begin
            chk("postrst_pld_data", pq[0].d, 64'h00000000_A5A5A5A5);
            chk("postrst_pld_keep", pq[0].k, 8'h0F);
            chk("postrst_pld_last", pq[0].l, 1'b1);
        end
        chk("postrst_drop_cnt", stat_drop_cnt, exp_drops);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
